// File: rtl/pair_frame_accum_pkg.sv
// Shared widths and FSM state type for the pair_frame_accum slice.
package pair_frame_accum_pkg;

  // Frame sum width: exact pair sum plus headroom for p_count samples.
  function automatic int f_sum_w(input int p_size, input int p_count);
    return 2 * p_size + 1 + $clog2(p_count);
  endfunction

  // Width able to hold a sample count from 0 to p_count inclusive.
  function automatic int f_len_w(input int p_count);
    return $clog2(p_count + 1);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/sum_fifo.sv
// Frame FIFO with registered first-word-fall-through output.
// Occupancy is tracked with wrap-bit pointers; a push is accepted while full
// when a pop happens in the same cycle.
module sum_fifo #(
  parameter int p_width = 22,
  parameter int p_depth = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [p_width-1:0] wr_data,
  output logic               full,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [p_width-1:0] rd_data
);

  localparam int AW = $clog2(p_depth);

  logic [p_width-1:0] mem_r [p_depth];
  logic [AW:0]        wr_ptr_r;
  logic [AW:0]        rd_ptr_r;
  logic [AW:0]        wr_ptr_nx_s;
  logic [AW:0]        rd_ptr_nx_s;
  logic               rd_valid_r;
  logic [p_width-1:0] rd_data_r;
  logic               full_s;
  logic               push_s;
  logic               pop_s;
  logic               bypass_s;
  logic [p_width-1:0] head_nx_s;

  // Handshake decode and next-pointer / next-head computation.
  always_comb begin
    full_s = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
             (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s  = rd_ready && rd_valid_r;
    push_s = wr_en && (!full_s || pop_s);
    if (push_s) begin
      wr_ptr_nx_s = wr_ptr_r + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_nx_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nx_s = rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_nx_s = rd_ptr_r;
    end
    // The next head is the slot being written now: forward the new word.
    bypass_s = push_s && (rd_ptr_nx_s[AW-1:0] == wr_ptr_r[AW-1:0]);
    if (bypass_s) begin
      head_nx_s = wr_data;
    end else begin
      head_nx_s = mem_r[rd_ptr_nx_s[AW-1:0]];
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Pointers and the registered output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {(AW + 1){1'b0}};
      rd_ptr_r   <= {(AW + 1){1'b0}};
      rd_valid_r <= 1'b0;
      rd_data_r  <= {p_width{1'b0}};
    end else begin
      wr_ptr_r   <= wr_ptr_nx_s;
      rd_ptr_r   <= rd_ptr_nx_s;
      rd_valid_r <= (wr_ptr_nx_s != rd_ptr_nx_s);
      if (wr_ptr_nx_s != rd_ptr_nx_s) begin
        rd_data_r <= head_nx_s;
      end
    end
  end

  assign full     = full_s;
  assign rd_valid = rd_valid_r;
  assign rd_data  = rd_data_r;

endmodule

// File: rtl/pair_frame_accum.sv
// Sums paired upstream words over frames of p_count valid samples and queues
// completed (or flushed) frame sums for a valid/ready consumer.
// Optional build macro PAIR_FRAME_ACCUM_AVG_EN: output the frame sum shifted
// right by clog2(p_count) instead of the raw sum.
module pair_frame_accum
  import pair_frame_accum_pkg::*;
#(
  parameter int p_size  = 8,
  parameter int p_count = 4,
  parameter int p_depth = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [2*p_size-1:0]                   i_param,
  input  logic [2*p_size-1:0]                   i_param_2,
  input  logic                                  dv,
  input  logic                                  i_flush,
  input  logic                                  i_clr,
  output logic [f_sum_w(p_size, p_count)-1:0]   o_sum,
  output logic [f_len_w(p_count)-1:0]           o_len,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic                                  o_drop
);

  localparam int SW = f_sum_w(p_size, p_count);
  localparam int LW = f_len_w(p_count);
  localparam int PW = 2 * p_size + 1;
  localparam logic [LW-1:0] LAST = LW'(p_count - 1);
`ifdef PAIR_FRAME_ACCUM_AVG_EN
  localparam int SH = $clog2(p_count);
`endif

  state_t          state_r;
  logic [SW-1:0]   acc_r;
  logic [LW-1:0]   cnt_r;
  logic            drop_r;
  logic [PW-1:0]   addend_s;
  logic [SW-1:0]   sum_s;
  logic [SW-1:0]   push_val_s;
  logic [LW-1:0]   len_s;
  logic            complete_s;
  logic            flush_s;
  logic            push_s;
  logic            pop_s;
  logic            lost_s;
  logic            full_s;
  logic [SW+LW-1:0] fifo_data_s;

  // Sample add, frame-close decisions and the value to enqueue.
  always_comb begin
    addend_s   = {1'b0, i_param} + {1'b0, i_param_2};
    if (dv) begin
      sum_s = acc_r + SW'(addend_s);
    end else begin
      sum_s = acc_r;
    end
    len_s      = cnt_r + {{(LW - 1){1'b0}}, dv};
    complete_s = dv && (cnt_r == LAST);
    flush_s    = i_flush && ((cnt_r != {LW{1'b0}}) || dv);
    push_s     = !i_clr && (complete_s || flush_s);
`ifdef PAIR_FRAME_ACCUM_AVG_EN
    push_val_s = sum_s >> SH;
`else
    push_val_s = sum_s;
`endif
    pop_s      = o_valid && i_ready;
    lost_s     = push_s && full_s && !pop_s;
  end

  // Frame FSM with accumulator and sample counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      acc_r   <= {SW{1'b0}};
      cnt_r   <= {LW{1'b0}};
    end else begin
      if (i_clr || push_s) begin
        acc_r <= {SW{1'b0}};
        cnt_r <= {LW{1'b0}};
      end else if (dv) begin
        acc_r <= sum_s;
        cnt_r <= len_s;
      end
      case (state_r)
        IDLE:    state_r <= (dv && !i_clr && !push_s) ? ACC : IDLE;
        ACC:     state_r <= (i_clr || push_s) ? IDLE : ACC;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Sticky record of a completed frame lost to a full queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_r <= 1'b0;
    end else if (i_clr) begin
      drop_r <= 1'b0;
    end else if (lost_s) begin
      drop_r <= 1'b1;
    end
  end

  sum_fifo #(
    .p_width (SW + LW),
    .p_depth (p_depth)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push_s),
    .wr_data  ({push_val_s, len_s}),
    .full     (full_s),
    .rd_ready (i_ready),
    .rd_valid (o_valid),
    .rd_data  (fifo_data_s)
  );

  assign o_sum  = fifo_data_s[LW +: SW];
  assign o_len  = fifo_data_s[LW-1:0];
  assign o_drop = drop_r;

endmodule
